// File: rtl/pwm_timer_if.sv
// Register bus shared by the PWM timer peripherals: one-cycle strobed access.
// bus_en is a single-cycle request; writes commit and read data registers at the next clk edge.
interface pwm_timer_if;
    logic        bus_en;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (output bus_en, output bus_we, output bus_addr, output bus_wdata, input bus_rdata);
    modport slave  (input bus_en, input bus_we, input bus_addr, input bus_wdata, output bus_rdata);
endinterface

// File: rtl/pwm_timer.sv
// Multi-channel PWM timer: shared prescaled up-counter, programmable top, one compare per output.
// Optional PWM_COMPARE_SHADOW_EN buffers TOP/COMPARE writes until the counter wraps.
module pwm_timer #(
    parameter int COUNTER_WIDTH = 16,
    parameter int OUTPUTS       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pwm_timer_if.slave         bus,
    output logic [OUTPUTS-1:0] pwm_out
);
    localparam int CW = COUNTER_WIDTH;

    logic          enable;
    logic [2:0]    scale;
    logic [6:0]    prescaler;
    logic [CW-1:0] top;
    logic [CW-1:0] counter;
    logic [CW-1:0] compare      [OUTPUTS];
    logic [CW-1:0] top_view;
    logic [CW-1:0] compare_view [OUTPUTS];
    logic [31:0]   rd_val;

    logic [5:0] word;
    logic       wr, rd, wr_config, wr_top, wr_counter;
    logic [6:0] ps_mask;
    logic       tick, wrap;
    logic       unused_bits;

    assign word        = bus.bus_addr[7:2];
    assign wr          = bus.bus_en & bus.bus_we;
    assign rd          = bus.bus_en & ~bus.bus_we;
    assign wr_config   = wr && (word == 6'd0);
    assign wr_top      = wr && (word == 6'd1);
    assign wr_counter  = wr && (word == 6'd2);
    assign ps_mask     = (7'd1 << scale) - 7'd1;
    assign tick        = enable && (prescaler == ps_mask);
    assign wrap        = tick && (counter >= top);
    assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enable <= 1'b0;
            scale  <= 3'd0;
        end else if (wr_config) begin
            enable <= bus.bus_wdata[0];
            scale  <= bus.bus_wdata[6:4];
        end
    end

    // A scale change or a COUNTER load restarts the tick phase from zero.
    always_ff @(posedge clk) begin
        if (!rst_n)
            prescaler <= 7'd0;
        else if (!enable || wr_counter || tick)
            prescaler <= 7'd0;
        else if (wr_config && (bus.bus_wdata[6:4] != scale))
            prescaler <= 7'd0;
        else
            prescaler <= prescaler + 7'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            counter <= '0;
        else if (wr_counter)
            counter <= bus.bus_wdata[CW-1:0];
        else if (wrap)
            counter <= '0;
        else if (tick)
            counter <= counter + CW'(1);
    end

`ifdef PWM_COMPARE_SHADOW_EN
    logic [CW-1:0] top_sh;
    logic [CW-1:0] compare_sh [OUTPUTS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            top_sh <= '0;
            top    <= '0;
            for (int i = 0; i < OUTPUTS; i++) begin
                compare_sh[i] <= '0;
                compare[i]    <= '0;
            end
        end else begin
            if (wr_top)
                top_sh <= bus.bus_wdata[CW-1:0];
            for (int i = 0; i < OUTPUTS; i++)
                if (wr && (word == 6'(4 + i)))
                    compare_sh[i] <= bus.bus_wdata[CW-1:0];
            // Active set only changes at a period boundary, or freely while stopped.
            if (!enable || wrap) begin
                top <= top_sh;
                for (int i = 0; i < OUTPUTS; i++)
                    compare[i] <= compare_sh[i];
            end
        end
    end

    always_comb begin
        top_view = top_sh;
        for (int i = 0; i < OUTPUTS; i++)
            compare_view[i] = compare_sh[i];
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            top <= '0;
            for (int i = 0; i < OUTPUTS; i++)
                compare[i] <= '0;
        end else begin
            if (wr_top)
                top <= bus.bus_wdata[CW-1:0];
            for (int i = 0; i < OUTPUTS; i++)
                if (wr && (word == 6'(4 + i)))
                    compare[i] <= bus.bus_wdata[CW-1:0];
        end
    end

    always_comb begin
        top_view = top;
        for (int i = 0; i < OUTPUTS; i++)
            compare_view[i] = compare[i];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            pwm_out <= '0;
        else
            for (int i = 0; i < OUTPUTS; i++)
                pwm_out[i] <= enable && (counter >= compare[i]);
    end

    always_comb begin
        rd_val = 32'd0;
        case (word)
            6'd0: rd_val = {25'd0, scale, 3'd0, enable};
            6'd1: rd_val = 32'(top_view);
            6'd2: rd_val = 32'(counter);
            6'd3: rd_val = 32'(pwm_out);
            default: begin
                for (int i = 0; i < OUTPUTS; i++)
                    if (word == 6'(4 + i))
                        rd_val = 32'(compare_view[i]);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            bus.bus_rdata <= 32'd0;
        else if (rd)
            bus.bus_rdata <= rd_val;
    end
endmodule

// File: tb/tb_pwm_timer.sv
// Directed self-checking bench for pwm_timer: register access, channel timing, status and edge cases.
`timescale 1ns/1ps
module tb_pwm_timer;
    logic       clk;
    logic       rst_n;
    logic [3:0] pwm_out;
    int         checks;
    int         failures;

    pwm_timer_if bus ();

    pwm_timer #(.COUNTER_WIDTH(16), .OUTPUTS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .pwm_out (pwm_out)
    );

    // 40 MHz clock
    initial clk = 1'b0;
    always #12.5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.bus_en    = 1'b1;
        bus.bus_we    = 1'b1;
        bus.bus_addr  = addr;
        bus.bus_wdata = data;
        @(negedge clk);
        bus.bus_en    = 1'b0;
        bus.bus_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.bus_en   = 1'b1;
        bus.bus_we   = 1'b0;
        bus.bus_addr = addr;
        @(negedge clk);
        bus.bus_en   = 1'b0;
        data         = bus.bus_rdata;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(addr, v);
        check(tag, v, exp);
    endtask

    // Cycle counts of one full high phase followed by one low phase, bounded.
    task automatic measure(input int ch, output int high_c, output int low_c);
        int n;
        high_c = 0;
        low_c  = 0;
        n = 0;
        while (pwm_out[ch] !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        n = 0;
        while (pwm_out[ch] !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        while (pwm_out[ch] === 1'b1 && high_c < 2000) begin @(negedge clk); high_c++; end
        while (pwm_out[ch] === 1'b0 && low_c < 2000) begin @(negedge clk); low_c++; end
    endtask

    initial begin
        logic [31:0] v0, v1;
        int hi, lo;
        int cnt_ch0, cnt_ch1_low, cnt_ch2, cnt_ch3;

        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.bus_en    = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = 8'h00;
        bus.bus_wdata = 32'd0;
        idle(3);
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_rdata", bus.bus_rdata, 32'd0);
        rst_n = 1'b1;
        check_reg("reset_config", 8'h00, 32'd0);
        check_reg("reset_top", 8'h04, 32'd0);
        check_reg("reset_counter", 8'h08, 32'd0);

        // Register write/read-back
        bus_write(8'h00, 32'h31);
        check_reg("rw_config", 8'h00, 32'h31);
        bus_write(8'h04, 32'd4999);
        check_reg("rw_top", 8'h04, 32'd4999);
        bus_write(8'h18, 32'd2500);
        check_reg("rw_compare2", 8'h18, 32'd2500);
        bus_write(8'h1C, 32'd3500);
        check_reg("rw_compare3", 8'h1C, 32'd3500);
        bus_write(8'h10, 32'hFFFF_1234);
        check_reg("rw_compare0_mask", 8'h10, 32'h1234);
        bus_write(8'h3C, 32'hDEAD_BEEF);
        check_reg("unmapped_read", 8'h3C, 32'd0);
        bus_write(8'h00, 32'h0);

        // Channels 2/3 at scale 3: 8 cycles per tick, TOP=49 -> period 400 cycles
        bus_write(8'h04, 32'd49);
        bus_write(8'h18, 32'd25);
        bus_write(8'h1C, 32'd35);
        bus_write(8'h08, 32'd0);
        bus_write(8'h00, 32'h31);
        measure(2, hi, lo);
        check("ch2_low", 32'(lo), 32'd200);
        check("ch2_period", 32'(hi + lo), 32'd400);
        measure(3, hi, lo);
        check("ch3_low", 32'(lo), 32'd280);
        check("ch3_period", 32'(hi + lo), 32'd400);

        // Channel 0 at scale 2: 4 cycles per tick, TOP=99 -> period 400 cycles
        bus_write(8'h00, 32'h0);
        bus_write(8'h04, 32'd99);
        bus_write(8'h10, 32'd20);
        bus_write(8'h08, 32'd0);
        bus_write(8'h00, 32'h21);
        measure(0, hi, lo);
        check("ch0_low", 32'(lo), 32'd80);
        check("ch0_period", 32'(hi + lo), 32'd400);

        // Counter polling while running
        bus_read(8'h08, v0);
        check("poll0_le_top", 32'(v0 <= 32'd99), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            idle(6);
            bus_read(8'h08, v1);
            check("poll_le_top", 32'(v1 <= 32'd99), 32'd1);
            check("poll_changed", 32'(v1 !== v0), 32'd1);
            v0 = v1;
        end

        // Status vs compare: compares are 20, 0, 25, 35; slow scale keeps COUNTER still
        bus_write(8'h00, 32'h71);
        bus_write(8'h08, 32'd15);
        idle(2);
        check_reg("status_c15", 8'h0C, 32'h2);
        check_reg("counter_c15", 8'h08, 32'd15);
        bus_write(8'h08, 32'd20);
        idle(2);
        check_reg("status_c20", 8'h0C, 32'h3);
        bus_write(8'h08, 32'd30);
        idle(2);
        check_reg("status_c30", 8'h0C, 32'h7);
        bus_write(8'h08, 32'd35);
        idle(2);
        check_reg("status_c35", 8'h0C, 32'hF);

        // Compare 0 always high, compare > TOP always low, scale 0 with TOP=9
        bus_write(8'h00, 32'h0);
        bus_write(8'h04, 32'd9);
        bus_write(8'h10, 32'd20);
        bus_write(8'h14, 32'd0);
        bus_write(8'h18, 32'd5);
        bus_write(8'h1C, 32'd10);
        bus_write(8'h08, 32'd0);
        bus_write(8'h00, 32'h01);
        idle(3);
        cnt_ch0 = 0; cnt_ch1_low = 0; cnt_ch2 = 0; cnt_ch3 = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (pwm_out[0] === 1'b1) cnt_ch0++;
            if (pwm_out[1] !== 1'b1) cnt_ch1_low++;
            if (pwm_out[2] === 1'b1) cnt_ch2++;
            if (pwm_out[3] === 1'b1) cnt_ch3++;
        end
        check("cmp0_never_low", 32'(cnt_ch1_low), 32'd0);
        check("cmp_top_plus1_never_high", 32'(cnt_ch3), 32'd0);
        check("cmp_above_top_never_high", 32'(cnt_ch0), 32'd0);
        check("cmp5_high_count", 32'(cnt_ch2), 32'd25);

        // Disable mid-period: outputs drop, counter freezes
        bus_write(8'h00, 32'h71);
        bus_write(8'h08, 32'd7);
        idle(3);
        check("pre_disable_pwm", 32'(pwm_out), 32'h6);
        bus_write(8'h00, 32'h70);
        idle(2);
        check("disable_pwm", 32'(pwm_out), 32'd0);
        idle(300);
        check_reg("disable_counter_frozen", 8'h08, 32'd7);
        check_reg("disable_status", 8'h0C, 32'd0);

        // Reset mid-period
        bus_write(8'h00, 32'h01);
        idle(13);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_pwm", 32'(pwm_out), 32'd0);
        check("midreset_rdata", bus.bus_rdata, 32'd0);
        rst_n = 1'b1;
        check_reg("midreset_config", 8'h00, 32'd0);
        check_reg("midreset_top", 8'h04, 32'd0);
        check_reg("midreset_counter", 8'h08, 32'd0);
        check_reg("midreset_compare2", 8'h18, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
